// File: rtl/shot_controller_pkg.sv
// Shared types and constants for the two-player shot controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package shot_controller_pkg;

    localparam int DEF_SHIP_CELLS = 17;
    localparam int DEF_BOARD_SIZE = 10;

    localparam logic [1:0] CELL_WATER = 2'b00;
    localparam logic [1:0] CELL_SHIP  = 2'b01;
    localparam logic [1:0] CELL_MISS  = 2'b10;
    localparam logic [1:0] CELL_HIT   = 2'b11;

    localparam logic [3:0] SEL_NONE = 4'hF;

    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_ESC   = 8'h76;

    // Index i of each table is the row (A-J) or column (0-9) it selects.
    localparam logic [7:0] SC_ROW [10] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24,
                                          8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B};
    localparam logic [7:0] SC_COL [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                          8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

    typedef enum logic [2:0] {IDLE, READ, WAIT, RESOLVE, OVER} state_t;

    typedef enum logic [1:0] {KEY_ROW, KEY_COL, KEY_ENTER, KEY_ESC} key_evt_t;

endpackage

// File: rtl/key_decoder.sv
// PS/2 set-2 byte decoder: drops break (F0 xx) and extended (E0) prefixes.
// Latency: event is combinational in the key_valid cycle; break flag is registered.
// Backpressure: none, every byte is consumed as it arrives.
module key_decoder
    import shot_controller_pkg::*;
(
    input  logic       clock50,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       evt_vld,
    output key_evt_t   evt_kind,
    output logic [3:0] evt_idx
);

    logic brk;
    logic known;

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            brk <= 1'b0;
        end else if (key_valid) begin
            if (brk)
                brk <= 1'b0;
            else if (key_code == SC_BREAK)
                brk <= 1'b1;
        end
    end

    // E0 and F0 are absent from every table, so they never raise an event.
    always_comb begin
        known    = 1'b0;
        evt_kind = KEY_ROW;
        evt_idx  = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (key_code == SC_ROW[i]) begin
                known    = 1'b1;
                evt_kind = KEY_ROW;
                evt_idx  = 4'(i);
            end
            if (key_code == SC_COL[i]) begin
                known    = 1'b1;
                evt_kind = KEY_COL;
                evt_idx  = 4'(i);
            end
        end
        if (key_code == SC_ENTER) begin
            known    = 1'b1;
            evt_kind = KEY_ENTER;
        end
        if (key_code == SC_ESC) begin
            known    = 1'b1;
            evt_kind = KEY_ESC;
        end
        evt_vld = key_valid && !brk && known;
    end

endmodule

// File: rtl/shot_controller.sv
// Battleship shot controller: keyboard cell selection, board read-modify-write, scoring.
// Latency: Enter in T -> cell_rd T+1, cell_we/shot_done T+3, next player_turn T+4.
// Backpressure: keys arriving outside IDLE are dropped (prefix tracking continues).
module shot_controller
    import shot_controller_pkg::*;
#(
    parameter int SHIP_CELLS = DEF_SHIP_CELLS,
    parameter int BOARD_SIZE = DEF_BOARD_SIZE
) (
    input  logic       clock50,
    input  logic       reset_n,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       cell_player,
    output logic [3:0] cell_row,
    output logic [3:0] cell_col,
    output logic       cell_rd,
    input  logic [1:0] cell_rdata,
    output logic       cell_we,
    output logic [1:0] cell_wdata,
    output logic [3:0] letter,
    output logic [3:0] number,
    output logic       player_turn,
    output logic       shot_done,
    output logic       shot_hit,
    output logic       shot_repeat,
    output logic       game_over,
    output logic       winner
);

    localparam logic [4:0] SHIP_MAX = 5'(SHIP_CELLS);

    state_t     state, state_nxt;
    logic       evt_vld;
    key_evt_t   evt_kind;
    logic [3:0] evt_idx;
    logic       sel_ok;
    logic       fire;
    logic [1:0] rdata_q;
    logic [4:0] hit_cnt [0:1];
    logic [4:0] cnt_cur;
    logic [4:0] cnt_post;

    key_decoder u_key_decoder (
        .clock50  (clock50),
        .reset_n  (reset_n),
        .key_valid(key_valid),
        .key_code (key_code),
        .evt_vld  (evt_vld),
        .evt_kind (evt_kind),
        .evt_idx  (evt_idx)
    );

    assign sel_ok    = (int'(letter) < BOARD_SIZE) && (int'(number) < BOARD_SIZE);
    assign fire      = (state == IDLE) && evt_vld && (evt_kind == KEY_ENTER) && sel_ok;
    assign cnt_cur   = hit_cnt[player_turn];
    assign cnt_post  = (cnt_cur < SHIP_MAX) ? cnt_cur + 5'd1 : cnt_cur;
    assign game_over = (state == OVER);

    always_comb begin
        state_nxt   = state;
        cell_rd     = 1'b0;
        cell_we     = 1'b0;
        cell_wdata  = CELL_WATER;
        shot_done   = 1'b0;
        shot_hit    = 1'b0;
        shot_repeat = 1'b0;
        case (state)
            IDLE: begin
                if (fire)
                    state_nxt = READ;
            end
            READ: begin
                cell_rd   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                state_nxt = RESOLVE;
            end
            RESOLVE: begin
                shot_done = 1'b1;
                state_nxt = IDLE;
                case (rdata_q)
                    CELL_WATER: begin
                        cell_we    = 1'b1;
                        cell_wdata = CELL_MISS;
                    end
                    CELL_SHIP: begin
                        cell_we    = 1'b1;
                        cell_wdata = CELL_HIT;
                        shot_hit   = 1'b1;
                        if (cnt_post == SHIP_MAX)
                            state_nxt = OVER;
                    end
                    default: shot_repeat = 1'b1;
                endcase
            end
            OVER: state_nxt = OVER;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            player_turn <= 1'b0;
            letter      <= SEL_NONE;
            number      <= SEL_NONE;
            winner      <= 1'b0;
            cell_player <= 1'b0;
            cell_row    <= 4'd0;
            cell_col    <= 4'd0;
            rdata_q     <= CELL_WATER;
            hit_cnt[0]  <= 5'd0;
            hit_cnt[1]  <= 5'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (evt_vld) begin
                        case (evt_kind)
                            KEY_ROW: letter <= evt_idx;
                            KEY_COL: number <= evt_idx;
                            KEY_ESC: begin
                                letter <= SEL_NONE;
                                number <= SEL_NONE;
                            end
                            default: ;
                        endcase
                    end
                    // Address is captured once and held through RESOLVE.
                    if (fire) begin
                        cell_player <= ~player_turn;
                        cell_row    <= letter;
                        cell_col    <= number;
                    end
                end
                WAIT: rdata_q <= cell_rdata;
                RESOLVE: begin
                    letter <= SEL_NONE;
                    number <= SEL_NONE;
                    if (shot_hit)
                        hit_cnt[player_turn] <= cnt_post;
                    if (state_nxt == OVER)
                        winner <= player_turn;
                    else if (!shot_repeat)
                        player_turn <= ~player_turn;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shot_controller.sv
// Directed bench for shot_controller with a behavioural two-board cell memory.
// Runs with SHIP_CELLS=2 so a win is reachable in a short sequence.
module tb_shot_controller;

    logic       clock50 = 1'b0;
    logic       reset_n;
    logic       key_valid;
    logic [7:0] key_code;
    logic       cell_player;
    logic [3:0] cell_row, cell_col;
    logic       cell_rd;
    logic [1:0] cell_rdata = 2'b00;
    logic       cell_we;
    logic [1:0] cell_wdata;
    logic [3:0] letter, number;
    logic       player_turn, shot_done, shot_hit, shot_repeat, game_over, winner;

    int checks = 0;
    int failures = 0;

    logic [1:0] board [0:1][0:9][0:9];
    int         we_cnt = 0;
    int         rd_cnt = 0;
    logic       pl_vld = 1'b0;
    logic       pl_clr = 1'b0;
    int         pl_p = 0, pl_r = 0, pl_c = 0;
    logic [1:0] pl_v = 2'b00;
    int         r0, w0;

    shot_controller #(.SHIP_CELLS(2), .BOARD_SIZE(10)) dut (
        .clock50    (clock50),
        .reset_n    (reset_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .cell_player(cell_player),
        .cell_row   (cell_row),
        .cell_col   (cell_col),
        .cell_rd    (cell_rd),
        .cell_rdata (cell_rdata),
        .cell_we    (cell_we),
        .cell_wdata (cell_wdata),
        .letter     (letter),
        .number     (number),
        .player_turn(player_turn),
        .shot_done  (shot_done),
        .shot_hit   (shot_hit),
        .shot_repeat(shot_repeat),
        .game_over  (game_over),
        .winner     (winner)
    );

    always #10 clock50 = ~clock50;

    always @(posedge clock50) begin
        if (cell_rd) begin
            cell_rdata <= board[cell_player][cell_row][cell_col];
            rd_cnt     <= rd_cnt + 1;
        end
        if (pl_clr) begin
            for (int p = 0; p < 2; p++)
                for (int r = 0; r < 10; r++)
                    for (int c = 0; c < 10; c++)
                        board[p][r][c] <= 2'b00;
        end else begin
            if (pl_vld)
                board[pl_p][pl_r][pl_c] <= pl_v;
            if (cell_we) begin
                board[cell_player][cell_row][cell_col] <= cell_wdata;
                we_cnt <= we_cnt + 1;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_key(input logic [7:0] code);
        @(negedge clock50);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clock50);
        key_valid = 1'b0;
        key_code  = 8'h00;
    endtask

    task automatic preload(input int p, input int r, input int c, input logic [1:0] v);
        @(negedge clock50);
        pl_p = p; pl_r = r; pl_c = c; pl_v = v;
        pl_vld = 1'b1;
        @(negedge clock50);
        pl_vld = 1'b0;
    endtask

    task automatic clear_board();
        @(negedge clock50);
        pl_clr = 1'b1;
        @(negedge clock50);
        pl_clr = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        key_valid = 1'b0;
        key_code  = 8'h00;
        clear_board();
        @(negedge clock50);
        check_eq("rst_letter", letter, 4'hF);
        check_eq("rst_number", number, 4'hF);
        check_eq("rst_turn", player_turn, 0);
        check_eq("rst_over", game_over, 0);
        check_eq("rst_winner", winner, 0);
        check_eq("rst_strobes", {cell_rd, cell_we, shot_done, shot_hit, shot_repeat}, 0);
        check_eq("rst_addr", {cell_player, cell_row, cell_col}, 0);
        check_eq("rst_wdata", cell_wdata, 0);
        reset_n = 1'b1;
        @(negedge clock50);

        // Water shot by player 0 at A3 on player 1's board.
        send_key(8'h1C);
        send_key(8'h26);
        check_eq("s1_letter", letter, 0);
        check_eq("s1_number", number, 3);
        send_key(8'h5A);
        check_eq("s1_rd", cell_rd, 1);
        check_eq("s1_addr", {cell_player, cell_row, cell_col}, {1'b1, 4'd0, 4'd3});
        check_eq("s1_we_early", cell_we, 0);
        @(negedge clock50);
        check_eq("s1_wait_strobes", {cell_rd, cell_we, shot_done}, 0);
        @(negedge clock50);
        check_eq("s1_we", cell_we, 1);
        check_eq("s1_wdata", cell_wdata, 2'b10);
        check_eq("s1_done_hit_rep", {shot_done, shot_hit, shot_repeat}, 3'b100);
        check_eq("s1_turn_t3", player_turn, 0);
        check_eq("s1_addr_stable", {cell_player, cell_row, cell_col}, {1'b1, 4'd0, 4'd3});
        @(negedge clock50);
        check_eq("s1_turn_t4", player_turn, 1);
        check_eq("s1_sel_clear", {letter, number}, 8'hFF);
        check_eq("s1_done_low", shot_done, 0);
        check_eq("s1_board", board[1][0][3], 2'b10);

        // Player 1 hits B3 with a break sequence and an E0 prefix in the stream.
        preload(0, 1, 3, 2'b01);
        send_key(8'h32);
        send_key(8'hF0);
        send_key(8'h1C);
        check_eq("s2_brk_discard", letter, 1);
        send_key(8'hE0);
        send_key(8'h26);
        check_eq("s2_ext_col", number, 3);
        send_key(8'h5A);
        check_eq("s2_addr", {cell_rd, cell_player, cell_row, cell_col}, {1'b1, 1'b0, 4'd1, 4'd3});
        repeat (2) @(negedge clock50);
        check_eq("s2_we_wdata", {cell_we, cell_wdata}, {1'b1, 2'b11});
        check_eq("s2_hit", {shot_done, shot_hit, shot_repeat}, 3'b110);
        @(negedge clock50);
        check_eq("s2_turn", player_turn, 0);
        check_eq("s2_board", board[0][1][3], 2'b11);

        // Escape, then Enter with only a row selected.
        send_key(8'h76);
        check_eq("s3_esc", {letter, number}, 8'hFF);
        send_key(8'h1C);
        r0 = rd_cnt;
        send_key(8'h5A);
        repeat (4) @(negedge clock50);
        check_eq("s3_no_rd", rd_cnt, r0);
        check_eq("s3_letter_kept", letter, 0);
        check_eq("s3_number_none", number, 4'hF);

        // Repeat shot at A5 which already holds a hit.
        preload(1, 0, 5, 2'b11);
        send_key(8'h2E);
        send_key(8'h5A);
        check_eq("s4_rd", cell_rd, 1);
        w0 = we_cnt;
        repeat (2) @(negedge clock50);
        check_eq("s4_flags", {shot_done, shot_hit, shot_repeat, cell_we}, 4'b1010);
        @(negedge clock50);
        check_eq("s4_turn", player_turn, 0);
        check_eq("s4_no_write", we_cnt, w0);
        check_eq("s4_sel_clear", {letter, number}, 8'hFF);

        // Player 0 sinks two ship cells with a player 1 miss in between.
        preload(1, 2, 2, 2'b01);
        preload(1, 2, 4, 2'b01);
        send_key(8'h21); send_key(8'h1E); send_key(8'h5A);
        repeat (3) @(negedge clock50);
        check_eq("s5_turn_a", player_turn, 1);
        check_eq("s5_not_over", game_over, 0);
        send_key(8'h23); send_key(8'h45); send_key(8'h5A);
        check_eq("s5_p1_target", cell_player, 0);
        repeat (3) @(negedge clock50);
        check_eq("s5_turn_b", player_turn, 0);
        send_key(8'h21); send_key(8'h25); send_key(8'h5A);
        repeat (2) @(negedge clock50);
        check_eq("s5_win_hit", {shot_done, shot_hit}, 2'b11);
        @(negedge clock50);
        check_eq("s5_over", game_over, 1);
        check_eq("s5_winner", winner, 0);
        check_eq("s5_turn_kept", player_turn, 0);
        r0 = rd_cnt;
        send_key(8'h1C);
        send_key(8'h5A);
        repeat (3) @(negedge clock50);
        check_eq("s5_keys_ignored", letter, 4'hF);
        check_eq("s5_no_rd", rd_cnt, r0);
        check_eq("s5_still_over", game_over, 1);

        // Reset asserted while the shot sits in WAIT.
        reset_n = 1'b0;
        @(negedge clock50);
        check_eq("s6_over_cleared", game_over, 0);
        reset_n = 1'b1;
        clear_board();
        send_key(8'h32); send_key(8'h16); send_key(8'h5A);
        @(negedge clock50);
        w0 = we_cnt;
        reset_n = 1'b0;
        #1;
        check_eq("s6_strobes", {cell_rd, cell_we, shot_done, shot_hit, shot_repeat}, 0);
        check_eq("s6_addr", {cell_player, cell_row, cell_col}, 0);
        check_eq("s6_sel", {letter, number}, 8'hFF);
        check_eq("s6_turn", player_turn, 0);
        repeat (2) @(negedge clock50);
        reset_n = 1'b1;
        repeat (4) @(negedge clock50);
        check_eq("s6_no_write", we_cnt, w0);
        check_eq("s6_idle_sel", {letter, number}, 8'hFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shot_controller.md
SHOT_CONTROLLER -- requirements
Module: shot_controller

Interface
REQ-001 SHALL have parameter SHIP_CELLS, default 17, giving the ship squares per player that must be hit to win.
REQ-002 SHALL have parameter BOARD_SIZE, default 10, giving rows and columns per board.
REQ-003 SHALL use one clock and an asynchronous active-low reset, with ports clock50 and reset_n.
REQ-004 clock50  in  1  system clock; all logic rises on posedge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 key_valid  in  1  one-cycle strobe; key_code holds a new PS/2 set-2 byte.
REQ-007 key_code  in  8  scan code byte.
REQ-008 cell_player  out  1  board being accessed (0 = player one, 1 = player two).
REQ-009 cell_row  out  4  row index 0-9 (letter A-J); cell_col  out  4  column index 0-9.
REQ-010 cell_rd  out  1  read strobe; cell_rdata  in  2  cell contents, valid exactly one cycle after cell_rd.
REQ-011 cell_we  out  1  write strobe; cell_wdata  out  2  new cell contents.
REQ-012 letter  out  4  selected row (0-9), or 4'hF if none; number  out  4  selected column, or 4'hF if none.
REQ-013 player_turn  out  1  current shooter; shot_done  out  1  one-cycle pulse when a shot resolves.
REQ-014 shot_hit  out  1  hit flag, valid with shot_done; shot_repeat  out  1  flag for a cell already fired on, valid with shot_done.
REQ-015 game_over  out  1  level signal; winner  out  1  winning player, valid while game_over is high.

Function
REQ-016 Cell encoding SHALL be 00 water, 01 ship, 10 miss, 11 hit.
REQ-017 Key decode: 1C,32,21,23,24,2B,34,33,43,3B SHALL select rows A-J; 45,16,1E,26,25,2E,36,3D,3E,46 SHALL select columns 0-9; 5A SHALL be Enter; 76 SHALL be Escape.
REQ-018 Byte F0 SHALL set a break flag; the next key_valid byte SHALL be discarded and SHALL clear the flag.
REQ-019 Byte E0 SHALL be discarded; the following byte SHALL be decoded normally.
REQ-020 Any other byte SHALL be ignored.
REQ-021 States SHALL be IDLE, READ, WAIT, RESOLVE and OVER; only IDLE SHALL act on decoded keys.
REQ-022 In IDLE, a row key SHALL overwrite letter and a column key SHALL overwrite number in the following cycle.
REQ-023 In IDLE, Escape SHALL set both letter and number to 4'hF.
REQ-024 In IDLE, Enter with letter or number equal to 4'hF SHALL be ignored; otherwise Enter SHALL go to READ.
REQ-025 READ SHALL last one cycle with cell_rd=1, cell_player=~player_turn, cell_row=letter and cell_col=number, then go to WAIT.
REQ-026 WAIT SHALL sample cell_rdata and go to RESOLVE.
REQ-027 RESOLVE, sampled value 00: SHALL assert cell_we with cell_wdata=10 and shot_hit=0.
REQ-028 RESOLVE, sampled value 01: SHALL assert cell_we with cell_wdata=11 and shot_hit=1, and SHALL increment the shooter's hit counter.
REQ-029 RESOLVE, sampled value 10 or 11: SHALL NOT write, SHALL set shot_repeat=1, and SHALL NOT toggle player_turn.
REQ-030 RESOLVE SHALL pulse shot_done, set letter and number to 4'hF, and keep address outputs stable.
REQ-031 After a non-repeat shot with the post-increment count below SHIP_CELLS, player_turn SHALL toggle at the end of RESOLVE and the state SHALL return to IDLE.
REQ-032 When the post-increment count equals SHIP_CELLS, the state SHALL go to OVER with winner equal to the shooter and player_turn unchanged.
REQ-033 OVER SHALL be terminal until reset, with game_over=1 and all keys ignored.
REQ-034 Latency: an Enter accepted in cycle T SHALL give cell_rd in T+1, cell_we and shot_done in T+3, and the new player_turn in T+4.
REQ-035 key_valid outside IDLE SHALL be dropped, except that F0 and E0 prefix tracking SHALL continue.
REQ-036 Hit counters SHALL be 5 bits, one per player, and SHALL saturate at SHIP_CELLS.
REQ-037 cell_rd, cell_we, shot_done, shot_hit and shot_repeat SHALL be 0 in every other cycle.

Reset
REQ-038 Asserting reset_n low SHALL act asynchronously, including mid-shot, with no cell_we issued afterwards.
REQ-039 Reset SHALL set state=IDLE, player_turn=0, letter=number=4'hF, the break flag to 0, and both counters to 0.
REQ-040 Reset SHALL set all strobes to 0, game_over=0, winner=0, cell_wdata=00, and cell_player, cell_row and cell_col to 0.

Structure
REQ-041 A shared package SHALL hold the cell encodings, scan-code constants, the state enumeration, BOARD_SIZE and SHIP_CELLS.
REQ-042 Scan-code decoding and break/extended tracking SHALL be one sub-module, key_decoder, producing a row/column/enter/escape event strobe.

Verification
REQ-043 Keys 1C, 26, 5A with a water cell -> cell_rd row 0, col 3, player 1; cell_wdata=10; shot_hit=0; player_turn becomes 1 at T+4.
REQ-044 Keys 1C, F0, 1C, 26, 5A -> only one row event is seen; the shot proceeds as in REQ-043.
REQ-045 Enter with only letter selected -> no cell_rd, and letter stays set.
REQ-046 A fired cell holding 11 -> shot_repeat=1, no cell_we, and player_turn unchanged.
REQ-047 SHIP_CELLS=2 with two ship hits by player 0 (interleaved with player 1 misses) -> game_over=1 and winner=0, after which keys are ignored.
REQ-048 reset_n pulsed low in the WAIT state -> no cell_we, and all outputs return to their reset values immediately.
